// File: rtl/matmul_sched_pkg.sv
// Shared types and elaboration helpers for the matmul tile scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package matmul_sched_pkg;

  // Wide enough for any practical tile grid; ports slice down to the real width.
  localparam int IDX_MAX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] m_idx;
    logic [IDX_MAX_W-1:0] n_idx;
    logic [IDX_MAX_W-1:0] k_idx;
    logic                 acc_clear;
    logic                 acc_emit;
  } cmd_t;

  // Number of tiles along one dimension.
  function automatic int tile_cnt(input int x, input int t);
    return x / t;
  endfunction

  // Index width for a dimension; never narrower than one bit.
  function automatic int idx_w(input int x, input int t);
    int c;
    c = x / t;
    return (c <= 1) ? 1 : $clog2(c);
  endfunction

  // Width of a counter that must hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/matmul_tile_scheduler_tile_index_counter.sv
// Nested m/k/n tile walker (n innermost) holding the current registered command.
// Latency: next command visible the cycle after adv or clr.
// Backpressure: holds its command while adv is low.
module tile_index_counter
  import matmul_sched_pkg::*;
#(
  parameter int MT = 2,
  parameter int NT = 2,
  parameter int KT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  output cmd_t cmd,
  output logic last,
  output logic nxt_clear
);

  cmd_t cmd_q;
  cmd_t cmd_d;
  logic n_last;
  logic k_last;
  logic m_last;
  logic [IDX_MAX_W-1:0] n_nxt;
  logic [IDX_MAX_W-1:0] k_nxt;
  logic [IDX_MAX_W-1:0] m_nxt;

  assign n_last    = (cmd_q.n_idx == IDX_MAX_W'(NT - 1));
  assign k_last    = (cmd_q.k_idx == IDX_MAX_W'(KT - 1));
  assign m_last    = (cmd_q.m_idx == IDX_MAX_W'(MT - 1));
  assign last      = n_last && k_last && m_last;
  // The command after this one starts a new output tile exactly when n wraps.
  assign nxt_clear = n_last;
  assign cmd       = cmd_q;

  // Wrap n first, carry into k, then into m.
  always_comb begin
    n_nxt = n_last ? '0 : cmd_q.n_idx + IDX_MAX_W'(1);
    k_nxt = cmd_q.k_idx;
    m_nxt = cmd_q.m_idx;
    if (n_last) begin
      k_nxt = k_last ? '0 : cmd_q.k_idx + IDX_MAX_W'(1);
      if (k_last) begin
        m_nxt = m_last ? '0 : cmd_q.m_idx + IDX_MAX_W'(1);
      end
    end
  end

  // Load the first command on clr, step to the following one on adv.
  always_comb begin
    cmd_d = cmd_q;
    if (clr) begin
      cmd_d.m_idx     = '0;
      cmd_d.n_idx     = '0;
      cmd_d.k_idx     = '0;
      cmd_d.acc_clear = 1'b1;
      cmd_d.acc_emit  = (NT == 1);
    end else if (adv) begin
      cmd_d.m_idx     = m_nxt;
      cmd_d.n_idx     = n_nxt;
      cmd_d.k_idx     = k_nxt;
      cmd_d.acc_clear = n_last;
      cmd_d.acc_emit  = (n_nxt == IDX_MAX_W'(NT - 1));
    end
  end

  // Command register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q <= '0;
    end else begin
      cmd_q <= cmd_d;
    end
  end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Streams tile commands (m outer, k middle, n inner) with bounded outstanding output tiles.
// Latency: first command one cycle after start; then one command per cycle when unstalled.
// Backpressure: cmd held stable under cmd_ready=0; new output tiles wait for free outstanding slots.
module matmul_tile_scheduler
  import matmul_sched_pkg::*;
#(
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int K               = 4,
  parameter int TILE_M          = 2,
  parameter int TILE_N          = 2,
  parameter int TILE_K          = 2,
  parameter int MAX_OUTSTANDING = 2,
  localparam int MT_W           = idx_w(M, TILE_M),
  localparam int NT_W           = idx_w(N, TILE_N),
  localparam int KT_W           = idx_w(K, TILE_K)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic [MT_W-1:0] cmd_m_idx,
  output logic [NT_W-1:0] cmd_n_idx,
  output logic [KT_W-1:0] cmd_k_idx,
  output logic            cmd_acc_clear,
  output logic            cmd_acc_emit,
  input  logic            rsp_valid
);

  localparam int MT          = tile_cnt(M, TILE_M);
  localparam int NT          = tile_cnt(N, TILE_N);
  localparam int KT          = tile_cnt(K, TILE_K);
  localparam int TOTAL_TILES = MT * KT;
  localparam int OUT_W       = cnt_w(MAX_OUTSTANDING);
  localparam int ACK_W       = cnt_w(TOTAL_TILES);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [ACK_W-1:0] ACK_ALL = ACK_W'(TOTAL_TILES);

  if ((M % TILE_M) != 0 || (N % TILE_N) != 0 || (K % TILE_K) != 0) begin : g_bad_tiling
    $error("matmul_tile_scheduler: tile sizes must divide the matrix dimensions");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_outstanding
    $error("matmul_tile_scheduler: MAX_OUTSTANDING must be at least 1");
  end

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [ACK_W-1:0] tiles_acked_q, tiles_acked_d;

  cmd_t cmd;
  logic cnt_clr;
  logic cnt_adv;
  logic last_cmd;
  logic nxt_clear;
  logic hs;
  logic emit_hs;
  logic rsp_ok;
  logic out_full_d;
  logic unused_idx_bits;

  tile_index_counter #(
    .MT(MT),
    .NT(NT),
    .KT(KT)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .adv      (cnt_adv),
    .cmd      (cmd),
    .last     (last_cmd),
    .nxt_clear(nxt_clear)
  );

  assign hs      = cmd_valid_q && cmd_ready;
  assign emit_hs = hs && cmd.acc_emit;
  // A response with nothing outstanding is ignored so the counter cannot wrap.
  assign rsp_ok  = rsp_valid && (outstanding_q != '0);

  // Outstanding tile count: emits add, responses retire, a coincident pair cancels.
  always_comb begin
    outstanding_d = outstanding_q;
    if (emit_hs && !rsp_ok) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!emit_hs && rsp_ok) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end
  end

  assign out_full_d = (outstanding_d == OUT_MAX);

  // Job sequencing; stall is only ever decided for a command that opens a new output tile.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    cmd_valid_d   = cmd_valid_q;
    tiles_acked_d = tiles_acked_q + ACK_W'(rsp_valid);
    cnt_clr       = 1'b0;
    cnt_adv       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = ISSUE;
          busy_d        = 1'b1;
          cnt_clr       = 1'b1;
          tiles_acked_d = '0;
          cmd_valid_d   = !out_full_d;
        end
      end
      ISSUE: begin
        if (hs) begin
          cnt_adv = 1'b1;
          if (last_cmd) begin
            state_d     = DRAIN;
            cmd_valid_d = 1'b0;
          end else begin
            cmd_valid_d = !(nxt_clear && out_full_d);
          end
        end else if (!cmd_valid_q) begin
          cmd_valid_d = !(cmd.acc_clear && out_full_d);
        end
      end
      DRAIN: begin
        if (tiles_acked_d == ACK_ALL) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cmd_valid_q   <= 1'b0;
      outstanding_q <= '0;
      tiles_acked_q <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cmd_valid_q   <= cmd_valid_d;
      outstanding_q <= outstanding_d;
      tiles_acked_q <= tiles_acked_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_m_idx     = cmd.m_idx[MT_W-1:0];
  assign cmd_n_idx     = cmd.n_idx[NT_W-1:0];
  assign cmd_k_idx     = cmd.k_idx[KT_W-1:0];
  assign cmd_acc_clear = cmd.acc_clear;
  assign cmd_acc_emit  = cmd.acc_emit;
  // Upper index bits beyond the port widths are always zero.
  assign unused_idx_bits = ^{cmd.m_idx, cmd.n_idx, cmd.k_idx};

  // A response without an outstanding tile is a datapath protocol violation.
  a_rsp_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
module tb_matmul_tile_scheduler;

  typedef struct {
    int m;
    int n;
    int k;
    int c;
    int e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start[3];
  logic cmd_ready[3];
  logic rsp_valid[3];
  logic busy[3];
  logic done[3];
  logic cmd_valid[3];
  logic m_o[3];
  logic n_o[3];
  logic k_o[3];
  logic clr_o[3];
  logic emit_o[3];

  int checks = 0;
  int failures = 0;
  int cur = 0;
  int cyc = 0;
  bit ready_rand;
  bit rsp_hold;
  bit same_rsp;
  int hs_cnt;
  int emit_cnt;
  int rsp_cnt;
  int done_cnt;
  exp_t exp_q[$];
  int rsp_due[$];
  bit prev_stall;
  int prev_fld;
  int s_v, s_m, s_n, s_k, s_c, s_e, s_b, s_d;

  always #5 clk = ~clk;

  matmul_tile_scheduler dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_m_idx(m_o[0]), .cmd_n_idx(n_o[0]), .cmd_k_idx(k_o[0]),
    .cmd_acc_clear(clr_o[0]), .cmd_acc_emit(emit_o[0]), .rsp_valid(rsp_valid[0])
  );

  matmul_tile_scheduler #(.N(4), .TILE_N(4)) dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_m_idx(m_o[1]), .cmd_n_idx(n_o[1]), .cmd_k_idx(k_o[1]),
    .cmd_acc_clear(clr_o[1]), .cmd_acc_emit(emit_o[1]), .rsp_valid(rsp_valid[1])
  );

  matmul_tile_scheduler #(.MAX_OUTSTANDING(1)) dut_c (
    .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_m_idx(m_o[2]), .cmd_n_idx(n_o[2]), .cmd_k_idx(k_o[2]),
    .cmd_acc_clear(clr_o[2]), .cmd_acc_emit(emit_o[2]), .rsp_valid(rsp_valid[2])
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    s_v = cmd_valid[cur];
    s_m = m_o[cur];
    s_n = n_o[cur];
    s_k = k_o[cur];
    s_c = clr_o[cur];
    s_e = emit_o[cur];
    s_b = busy[cur];
    s_d = done[cur];
  endtask

  // Expected command stream of one job: m outer, k middle, n inner.
  task automatic push_job(input int mt, input int nt, input int kt);
    exp_t x;
    for (int m = 0; m < mt; m++)
      for (int k = 0; k < kt; k++)
        for (int n = 0; n < nt; n++) begin
          x.m = m; x.n = n; x.k = k;
          x.c = (n == 0) ? 1 : 0;
          x.e = (n == nt - 1) ? 1 : 0;
          exp_q.push_back(x);
        end
  endtask

  // One clock: sample after the edge, check, then drive inputs for the next edge.
  task automatic step();
    exp_t x;
    int fld;
    bit hs;
    @(posedge clk);
    #1;
    cyc++;
    sample();
    fld = s_m * 16 + s_n * 8 + s_k * 4 + s_c * 2 + s_e;
    if (prev_stall) begin
      chk("valid_held", s_v, 1);
      chk("fields_stable", fld, prev_fld);
    end
    if (s_d == 1) begin
      done_cnt++;
      chk("busy_low_in_done", s_b, 0);
    end
    cmd_ready[cur] = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    hs = (s_v == 1) && cmd_ready[cur];
    rsp_valid[cur] = 1'b0;
    if (hs) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("extra_cmd", exp_q.size(), 1);
      end else begin
        x = exp_q.pop_front();
        chk("cmd_m", s_m, x.m);
        chk("cmd_n", s_n, x.n);
        chk("cmd_k", s_k, x.k);
        chk("cmd_clear", s_c, x.c);
        chk("cmd_emit", s_e, x.e);
      end
      if (s_e == 1) begin
        emit_cnt++;
        rsp_due.push_back(cyc + 3);
      end
    end
    if (rsp_due.size() > 0) begin
      if (same_rsp ? (hs && s_e == 1 && emit_cnt == 2) : (!rsp_hold && rsp_due[0] <= cyc)) begin
        void'(rsp_due.pop_front());
        rsp_valid[cur] = 1'b1;
        rsp_cnt++;
      end
    end
    prev_stall = (s_v == 1) && !cmd_ready[cur];
    prev_fld = fld;
  endtask

  task automatic begin_test(input int sel);
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      cmd_ready[i] = 1'b0;
      rsp_valid[i] = 1'b0;
    end
    cur = sel;
    hs_cnt = 0; emit_cnt = 0; rsp_cnt = 0; done_cnt = 0;
    exp_q.delete();
    rsp_due.delete();
    prev_stall = 0;
    ready_rand = 0; rsp_hold = 0; same_rsp = 0;
    sample();
  endtask

  task automatic kick();
    start[cur] = 1'b1;
    step();
    start[cur] = 1'b0;
    chk("busy_after_start", s_b, 1);
  endtask

  task automatic run_to_done(input int budget);
    int i;
    i = 0;
    while (s_d != 1 && i < budget) begin
      step();
      i++;
    end
    chk("done_seen", s_d, 1);
  endtask

  task automatic finish_job(input int n_cmds, input int n_tiles);
    repeat (6) step();
    chk("cmd_count", hs_cnt, n_cmds);
    chk("rsp_count", rsp_cnt, n_tiles);
    chk("done_pulses", done_cnt, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_idle", s_b, 0);
    chk("valid_idle", s_v, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int i;
    bit saw_done;
    rst = 1'b0;
    begin_test(0);
    #12;
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_valid", cmd_valid[0], 0);
    chk("rst_m", m_o[0], 0);
    chk("rst_n", n_o[0], 0);
    chk("rst_k", k_o[0], 0);
    chk("rst_clear", clr_o[0], 0);
    chk("rst_emit", emit_o[0], 0);
    chk("rst_outstanding", dut_a.outstanding_q, 0);
    chk("rst_acked", dut_a.tiles_acked_q, 0);
    chk("rst_valid_b", cmd_valid[1], 0);
    chk("rst_valid_c", cmd_valid[2], 0);
    @(negedge clk);
    rst = 1'b1;

    // Default geometry, full throughput.
    begin_test(0);
    push_job(2, 2, 2);
    kick();
    run_to_done(200);
    finish_job(8, 4);

    // Single reduction step per output tile.
    begin_test(1);
    push_job(2, 1, 2);
    kick();
    chk("first_clear_b", s_c, 1);
    chk("first_emit_b", s_e, 1);
    run_to_done(200);
    finish_job(4, 4);

    // Random backpressure.
    begin_test(0);
    ready_rand = 1;
    push_job(2, 2, 2);
    kick();
    run_to_done(400);
    finish_job(8, 4);

    // One outstanding tile, response withheld.
    begin_test(2);
    push_job(2, 2, 2);
    rsp_hold = 1;
    kick();
    i = 0;
    while (emit_cnt < 1 && i < 50) begin
      step();
      i++;
    end
    chk("first_emit_seen", emit_cnt, 1);
    step();
    chk("stall_after_emit", s_v, 0);
    for (int j = 0; j < 4; j++) begin
      step();
      chk("stall_held", s_v, 0);
    end
    rsp_hold = 0;
    step();
    chk("stall_until_rsp", s_v, 0);
    chk("rsp_released", rsp_cnt, 1);
    step();
    chk("reassert_after_rsp", s_v, 1);
    chk("reassert_k", s_k, 1);
    chk("reassert_clear", s_c, 1);
    run_to_done(400);
    finish_job(8, 4);

    // Emit handshake and response in the same cycle.
    begin_test(0);
    push_job(2, 2, 2);
    rsp_hold = 1;
    same_rsp = 1;
    kick();
    i = 0;
    while (emit_cnt < 2 && i < 50) begin
      step();
      i++;
    end
    chk("same_cycle_rsp", rsp_cnt, 1);
    same_rsp = 0;
    rsp_hold = 0;
    step();
    chk("outstanding_same_cycle", dut_a.outstanding_q, 1);
    chk("no_stall_third_tile", s_v, 1);
    run_to_done(400);
    finish_job(8, 4);

    // Start pulses while busy and during the done cycle are ignored.
    begin_test(0);
    push_job(2, 2, 2);
    kick();
    i = 0;
    while (s_d != 1 && i < 300) begin
      start[0] = (i % 3 == 0);
      step();
      i++;
    end
    saw_done = (s_d == 1);
    chk("done_seen_spam", saw_done, 1);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("start_in_done_ignored", s_b, 0);
    repeat (10) step();
    chk("no_second_job", s_b, 0);
    finish_job(8, 4);

    // Reset in the middle of issuing, then a clean restart.
    begin_test(0);
    push_job(2, 2, 2);
    kick();
    i = 0;
    while (hs_cnt < 3 && i < 50) begin
      step();
      i++;
    end
    @(posedge clk);
    #1;
    sample();
    chk("valid_before_rst", s_v, 1);
    rst = 1'b0;
    #1;
    sample();
    chk("mid_rst_busy", s_b, 0);
    chk("mid_rst_valid", s_v, 0);
    chk("mid_rst_m", s_m, 0);
    chk("mid_rst_n", s_n, 0);
    chk("mid_rst_k", s_k, 0);
    chk("mid_rst_clear", s_c, 0);
    chk("mid_rst_emit", s_e, 0);
    chk("mid_rst_outstanding", dut_a.outstanding_q, 0);
    begin_test(0);
    @(negedge clk);
    rst = 1'b1;
    push_job(2, 2, 2);
    kick();
    chk("restart_m", s_m, 0);
    chk("restart_n", s_n, 0);
    chk("restart_k", s_k, 0);
    run_to_done(200);
    finish_job(8, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
